// File: rtl/mem_bus_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_decoder_pkg
// Description : Shared state encoding, memory-map constants and the window
//               decode helper for the CPU memory bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_decoder_pkg;

    // Decoder state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAM  = 2'd1,
        ST_IO   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Memory map, shared with the firmware linker script
    localparam logic [31:0] c_RAM_BASE  = 32'h0000_0000;
    localparam int unsigned c_RAM_BYTES = 16384;
    localparam logic [31:0] c_IO_BASE   = 32'h1000_0000;
    localparam int unsigned c_IO_BYTES  = 4096;
    localparam int unsigned c_TIMEOUT   = 255;
    localparam logic [31:0] c_ERR_DATA  = 32'hDEAD_BEEF;

    // True when base <= addr < base+size; the offset form stays correct even
    // when base+size wraps to 2**32.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < size);
    endfunction

endpackage : mem_bus_decoder_pkg
`default_nettype wire

// File: rtl/bus_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_timer
// Description : 8-bit clear/enable wait counter. o_expired is high during the
//               TIMEOUT-th enabled cycle since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Count enabled cycles; hold at the last value so the flag stays asserted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == c_LAST);

endmodule : bus_timeout_timer
`default_nettype wire

// File: rtl/mem_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_decoder
// Description : Routes CPU native-port requests to on-chip RAM or the IO
//               window with base-relative addresses, returns a registered
//               one-cycle ready, and answers unmapped or stalled accesses
//               with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_decoder
    import mem_bus_decoder_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = c_RAM_BASE,
    parameter int unsigned RAM_BYTES = c_RAM_BYTES,
    parameter logic [31:0] IO_BASE   = c_IO_BASE,
    parameter int unsigned IO_BYTES  = c_IO_BYTES,
    parameter int unsigned TIMEOUT   = c_TIMEOUT,
    parameter logic [31:0] ERR_DATA  = c_ERR_DATA
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        ram_valid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        io_valid,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    input  logic        io_ready,
    input  logic [31:0] io_rdata,
    output logic        bus_error,
    output logic [7:0]  err_count
);

    state_t      r_state;
    logic        r_cpu_ready;
    logic [31:0] r_cpu_rdata;
    logic        r_ram_valid;
    logic        r_io_valid;
    logic [31:0] r_ram_addr;
    logic [31:0] r_io_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bus_error;
    logic [7:0]  r_err_count;

    logic        w_hit_ram;
    logic        w_hit_io;
    logic        w_waiting;
    logic        w_expired;
    logic [7:0]  w_err_next;

    assign w_hit_ram  = in_window(cpu_addr, RAM_BASE, 32'(RAM_BYTES));
    assign w_hit_io   = in_window(cpu_addr, IO_BASE, 32'(IO_BYTES));
    assign w_waiting  = (r_state == ST_RAM) || (r_state == ST_IO);
    assign w_err_next = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;

    // Wait counter runs only while a slave is addressed
    bus_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (!w_waiting),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    // Request sequencing: accept in IDLE, wait on the addressed slave, respond
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= 32'd0;
            r_ram_valid <= 1'b0;
            r_io_valid  <= 1'b0;
            r_ram_addr  <= 32'd0;
            r_io_addr   <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_bus_error <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            // Response strobes are single-cycle unless re-armed below
            r_cpu_ready <= 1'b0;
            r_bus_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        if (w_hit_ram) begin
                            r_state     <= ST_RAM;
                            r_ram_valid <= 1'b1;
                            r_ram_addr  <= cpu_addr - RAM_BASE;
                            r_wdata     <= cpu_wdata;
                            r_wstrb     <= cpu_wstrb;
                        end else if (w_hit_io) begin
                            r_state     <= ST_IO;
                            r_io_valid  <= 1'b1;
                            r_io_addr   <= cpu_addr - IO_BASE;
                            r_wdata     <= cpu_wdata;
                            r_wstrb     <= cpu_wstrb;
                        end else begin
                            r_state     <= ST_RESP;
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= ERR_DATA;
                            r_bus_error <= 1'b1;
                            r_err_count <= w_err_next;
                        end
                    end
                end
                ST_RAM: begin
                    // A ready on the expiry edge still counts as success
                    if (ram_ready) begin
                        r_state     <= ST_RESP;
                        r_ram_valid <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= ram_rdata;
                    end else if (w_expired) begin
                        r_state     <= ST_RESP;
                        r_ram_valid <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= ERR_DATA;
                        r_bus_error <= 1'b1;
                        r_err_count <= w_err_next;
                    end
                end
                ST_IO: begin
                    if (io_ready) begin
                        r_state     <= ST_RESP;
                        r_io_valid  <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= io_rdata;
                    end else if (w_expired) begin
                        r_state     <= ST_RESP;
                        r_io_valid  <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= ERR_DATA;
                        r_bus_error <= 1'b1;
                        r_err_count <= w_err_next;
                    end
                end
                // One response cycle; the idle cycle that follows keeps a
                // slave from seeing valid right after its own ready
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign ram_valid = r_ram_valid;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_wdata;
    assign ram_wstrb = r_wstrb;
    assign io_valid  = r_io_valid;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_wdata;
    assign io_wstrb  = r_wstrb;
    assign bus_error = r_bus_error;
    assign err_count = r_err_count;

endmodule : mem_bus_decoder
`default_nettype wire

// File: tb/tb_mem_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_decoder
// Description : Self-checking bench for mem_bus_decoder with behavioural RAM
//               and IO slaves and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_decoder;

    localparam int          TO     = 4;
    localparam logic [31:0] RB     = 32'h0000_0000;
    localparam logic [31:0] IB     = 32'h1000_0000;
    localparam longint      RBYTES = 16384;
    localparam longint      IBYTES = 4096;
    localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;

    logic        clk, resetn;
    logic        cpu_valid, cpu_ready, ram_valid, ram_ready, io_valid, io_ready, bus_error;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic [3:0]  cpu_wstrb, ram_wstrb, io_wstrb;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_err  = 0;

    // slave behaviour knobs and protocol monitor
    int ram_lat = 0, io_lat = 0, ram_cnt = 0, io_cnt = 0, ram_refire = 0, io_refire = 0;
    logic [31:0] slv_ram [4096];
    logic [31:0] slv_io  [1024];
    logic [31:0] ref_ram [4096];
    logic [31:0] ref_io  [1024];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          ram_cyc;
        int          io_cyc;
        int          both;
        int          unstable;
        logic [31:0] raddr;
        logic [31:0] iaddr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        ready_after;
        logic        err_after;
    } obs_t;

    mem_bus_decoder #(
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .ram_valid (ram_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstrb (ram_wstrb),
        .ram_ready (ram_ready),
        .ram_rdata (ram_rdata),
        .io_valid  (io_valid),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_wstrb  (io_wstrb),
        .io_ready  (io_ready),
        .io_rdata  (io_rdata),
        .bus_error (bus_error),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // 0 = RAM, 1 = IO, 2 = unmapped, decided with wide arithmetic on the map
    function automatic int region(input logic [31:0] a);
        longint la;
        la = longint'(a);
        if (la >= longint'(RB) && la < longint'(RB) + RBYTES) return 0;
        if (la >= longint'(IB) && la < longint'(IB) + IBYTES) return 1;
        return 2;
    endfunction

    function automatic int exp_errcnt();
        return (ref_err > 255) ? 255 : ref_err;
    endfunction

    // Behavioural slaves: answer after *_lat waiting cycles, one-cycle ready pulse
    initial begin
        ram_ready = 1'b0; io_ready = 1'b0; ram_rdata = '0; io_rdata = '0;
        forever begin
            @(negedge clk);
            if (ram_ready) begin
                ram_ready = 1'b0;
                if (ram_valid) ram_refire++;
            end else if (ram_valid) begin
                if (ram_cnt >= ram_lat) begin
                    ram_ready = 1'b1;
                    ram_rdata = slv_ram[ram_addr[13:2]];
                    if (ram_wstrb != 4'd0)
                        slv_ram[ram_addr[13:2]] = merge(slv_ram[ram_addr[13:2]], ram_wdata, ram_wstrb);
                    ram_cnt = 0;
                end else begin
                    ram_cnt++;
                    ram_rdata = $urandom;
                end
            end else begin
                ram_cnt = 0;
            end
            if (io_ready) begin
                io_ready = 1'b0;
                if (io_valid) io_refire++;
            end else if (io_valid) begin
                if (io_cnt >= io_lat) begin
                    io_ready = 1'b1;
                    io_rdata = slv_io[io_addr[11:2]];
                    if (io_wstrb != 4'd0)
                        slv_io[io_addr[11:2]] = merge(slv_io[io_addr[11:2]], io_wdata, io_wstrb);
                    io_cnt = 0;
                end else begin
                    io_cnt++;
                    io_rdata = $urandom;
                end
            end else begin
                io_cnt = 0;
            end
        end
    end

    // Issue one CPU request and record what the bus did (no judgement here)
    task automatic drive_access(input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ws, output obs_t o);
        o.rdata = '0; o.err = 1'b0; o.lat = 0; o.ram_cyc = 0; o.io_cyc = 0; o.both = 0;
        o.unstable = 0; o.raddr = '0; o.iaddr = '0; o.wd = '0; o.ws = '0;
        o.ready_after = 1'b0; o.err_after = 1'b0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (ram_valid && io_valid) o.both++;
            if (ram_valid) begin
                o.ram_cyc++;
                if (o.ram_cyc == 1) begin
                    o.raddr = ram_addr; o.wd = ram_wdata; o.ws = ram_wstrb;
                end else if (ram_addr !== o.raddr || ram_wdata !== o.wd || ram_wstrb !== o.ws) begin
                    o.unstable++;
                end
            end
            if (io_valid) begin
                o.io_cyc++;
                if (o.io_cyc == 1) begin
                    o.iaddr = io_addr; o.wd = io_wdata; o.ws = io_wstrb;
                end else if (io_addr !== o.iaddr || io_wdata !== o.wd || io_wstrb !== o.ws) begin
                    o.unstable++;
                end
            end
            if (cpu_ready) begin
                o.lat = n; o.rdata = cpu_rdata; o.err = bus_error;
                break;
            end
        end
        cpu_valid = 1'b0;
        @(negedge clk);
        o.ready_after = cpu_ready;
        o.err_after   = bus_error;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cpu_ready, ram_valid, io_valid, bus_error} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {cpu_ready, ram_valid, io_valid, bus_error});
        end
        n_checks++;
        if (cpu_rdata !== 32'd0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_regs: rdata %h errcnt %0d expected 0/0", cpu_rdata, err_count);
        end
    endtask

    task automatic test_ram_read();
        obs_t o;
        slv_ram[5] = 32'h1234_5678; ref_ram[5] = 32'h1234_5678;
        ram_lat = 0;
        drive_access(RB + 32'h14, 32'h0, 4'h0, o);
        n_checks++;
        if (o.raddr !== 32'h14 || o.ram_cyc != 1 || o.io_cyc != 0) begin
            n_fail++; $display("FAIL ram_read_bus: addr %h cyc %0d/%0d expected 14 1/0", o.raddr, o.ram_cyc, o.io_cyc);
        end
        n_checks++;
        if (o.rdata !== 32'h1234_5678 || o.err !== 1'b0 || o.lat != 2) begin
            n_fail++; $display("FAIL ram_read_resp: data %h err %b lat %0d expected 12345678 0 2", o.rdata, o.err, o.lat);
        end
        n_checks++;
        if (o.ready_after !== 1'b0) begin
            n_fail++; $display("FAIL ram_read_pulse: ready after %b expected 0", o.ready_after);
        end
    endtask

    task automatic test_io_write();
        obs_t o;
        io_lat = 2;
        drive_access(IB + 32'h8, 32'h0000_00AB, 4'b0001, o);
        ref_io[2] = merge(ref_io[2], 32'h0000_00AB, 4'b0001);
        n_checks++;
        if (o.iaddr !== 32'h8 || o.ws !== 4'b0001 || o.wd !== 32'hAB || o.ram_cyc != 0 || o.io_cyc != 3) begin
            n_fail++; $display("FAIL io_write_bus: addr %h ws %b wd %h cyc %0d/%0d expected 8 0001 ab 0/3", o.iaddr, o.ws, o.wd, o.ram_cyc, o.io_cyc);
        end
        n_checks++;
        if (o.err !== 1'b0 || o.lat != 4) begin
            n_fail++; $display("FAIL io_write_resp: err %b lat %0d expected 0 4", o.err, o.lat);
        end
        io_lat = 0;
        drive_access(IB + 32'h8, 32'h0, 4'h0, o);
        n_checks++;
        if (o.rdata !== ref_io[2]) begin
            n_fail++; $display("FAIL io_readback: got %h expected %h", o.rdata, ref_io[2]);
        end
    endtask

    task automatic test_unmapped();
        obs_t o;
        drive_access(32'h2000_0000, 32'h0, 4'h0, o);
        ref_err++;
        n_checks++;
        if (o.ram_cyc != 0 || o.io_cyc != 0 || o.lat != 1) begin
            n_fail++; $display("FAIL unmapped_bus: cyc %0d/%0d lat %0d expected 0/0 1", o.ram_cyc, o.io_cyc, o.lat);
        end
        n_checks++;
        if (o.rdata !== ERRD || o.err !== 1'b1 || o.err_after !== 1'b0 || err_count !== 8'(exp_errcnt())) begin
            n_fail++; $display("FAIL unmapped_resp: data %h err %b/%b cnt %0d expected deadbeef 1/0 %0d", o.rdata, o.err, o.err_after, err_count, exp_errcnt());
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        io_lat = 50;
        drive_access(IB + 32'h10, 32'h0, 4'h0, o);
        ref_err++;
        n_checks++;
        if (o.io_cyc != TO || o.lat != TO + 1) begin
            n_fail++; $display("FAIL timeout_len: io cycles %0d lat %0d expected %0d %0d", o.io_cyc, o.lat, TO, TO + 1);
        end
        n_checks++;
        if (o.rdata !== ERRD || o.err !== 1'b1 || err_count !== 8'(exp_errcnt())) begin
            n_fail++; $display("FAIL timeout_resp: data %h err %b cnt %0d expected deadbeef 1 %0d", o.rdata, o.err, err_count, exp_errcnt());
        end
        // ready arriving on the expiry edge wins
        io_lat = TO - 1;
        drive_access(IB + 32'h10, 32'h0, 4'h0, o);
        n_checks++;
        if (o.rdata !== ref_io[4] || o.err !== 1'b0 || o.lat != TO + 1 || err_count !== 8'(exp_errcnt())) begin
            n_fail++; $display("FAIL timeout_tie: data %h err %b lat %0d cnt %0d expected %h 0 %0d %0d", o.rdata, o.err, o.lat, err_count, ref_io[4], TO + 1, exp_errcnt());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        int   got = 0, gap = 0, phase = 0, refire0;
        refire0 = ram_refire;
        ram_lat = 1;
        d1 = '0; d2 = '0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = RB + 32'h20; cpu_wdata = '0; cpu_wstrb = 4'h0;
        for (int n = 0; n < 40 && got < 2; n++) begin
            @(negedge clk);
            if (phase == 0 && ram_valid) phase = 1;
            else if (phase == 1 && !ram_valid) begin phase = 2; gap = 1; end
            else if (phase == 2 && !ram_valid) gap++;
            else if (phase == 2 && ram_valid) phase = 3;
            if (cpu_ready) begin
                if (got == 0) begin d1 = cpu_rdata; cpu_addr = RB + 32'h24; end
                else begin d2 = cpu_rdata; cpu_valid = 1'b0; end
                got++;
            end
        end
        cpu_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (got != 2 || d1 !== ref_ram[8] || d2 !== ref_ram[9]) begin
            n_fail++; $display("FAIL b2b_data: got %0d resp %h %h expected 2 %h %h", got, d1, d2, ref_ram[8], ref_ram[9]);
        end
        n_checks++;
        if (phase != 3 || gap != 2 || ram_refire != refire0) begin
            n_fail++; $display("FAIL b2b_gap: phase %0d gap %0d refires %0d expected 3 2 0", phase, gap, ram_refire - refire0);
        end
    endtask

    task automatic test_random(input int count);
        obs_t o;
        logic [31:0] a, wd, exp_d, exp_addr;
        logic [3:0]  ws;
        int sel, kind, lat, idx, ok, exp_lat, exp_rc, exp_ic;
        for (int t = 0; t < count; t++) begin
            sel = $urandom_range(9, 0);
            case (sel)
                0, 1, 2, 3: a = RB + {18'd0, 12'($urandom_range(4095, 0)), 2'b00};
                4:          a = RB + 32'(RBYTES - 4);
                5, 6:       a = IB + {20'd0, 10'($urandom_range(1023, 0)), 2'b00};
                7:          a = IB + 32'(IBYTES - 4);
                8: begin
                    case ($urandom_range(2, 0))
                        0:       a = RB + 32'(RBYTES);
                        1:       a = IB - 32'd4;
                        default: a = IB + 32'(IBYTES);
                    endcase
                end
                default:    a = 32'h8000_0000 | $urandom;
            endcase
            ws  = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
            wd  = $urandom;
            lat = $urandom_range(5, 0);
            ram_lat = lat; io_lat = lat;
            kind = region(a);
            ok   = (kind != 2) && (lat < TO);
            idx  = (kind == 0) ? int'((a - RB) >> 2) : int'((a - IB) >> 2);
            exp_addr = (kind == 0) ? a - RB : a - IB;
            if (kind == 2) begin exp_lat = 1; exp_rc = 0; exp_ic = 0; end
            else begin
                exp_lat = ok ? lat + 2 : TO + 1;
                exp_rc  = (kind == 0) ? (ok ? lat + 1 : TO) : 0;
                exp_ic  = (kind == 1) ? (ok ? lat + 1 : TO) : 0;
            end
            if (!ok) exp_d = ERRD;
            else exp_d = (kind == 0) ? ref_ram[idx] : ref_io[idx];
            drive_access(a, wd, ws, o);
            if (!ok) ref_err++;
            else if (ws != 4'h0 && kind == 0) ref_ram[idx] = merge(ref_ram[idx], wd, ws);
            else if (ws != 4'h0 && kind == 1) ref_io[idx]  = merge(ref_io[idx], wd, ws);
            n_checks++;
            if (o.lat != exp_lat || o.err !== (ok == 0) || o.ram_cyc != exp_rc || o.io_cyc != exp_ic) begin
                n_fail++; $display("FAIL rnd_timing #%0d a=%h: lat %0d err %b cyc %0d/%0d expected %0d %0d %0d/%0d", t, a, o.lat, o.err, o.ram_cyc, o.io_cyc, exp_lat, ok == 0, exp_rc, exp_ic);
            end
            if (ws == 4'h0 || !ok) begin
                n_checks++;
                if (o.rdata !== exp_d) begin
                    n_fail++; $display("FAIL rnd_rdata #%0d a=%h: got %h expected %h", t, a, o.rdata, exp_d);
                end
            end
            if (kind != 2) begin
                n_checks++;
                if (((kind == 0) ? o.raddr : o.iaddr) !== exp_addr || o.wd !== wd || o.ws !== ws || o.unstable != 0) begin
                    n_fail++; $display("FAIL rnd_fwd #%0d a=%h: addr %h/%h wd %h ws %b unstable %0d expected %h wd %h ws %b", t, a, o.raddr, o.iaddr, o.wd, o.ws, o.unstable, exp_addr, wd, ws);
                end
            end
            n_checks++;
            if (o.both != 0 || o.ready_after !== 1'b0 || o.err_after !== 1'b0 || err_count !== 8'(exp_errcnt())) begin
                n_fail++; $display("FAIL rnd_misc #%0d: both %0d rdy_after %b err_after %b cnt %0d expected 0 0 0 %0d", t, o.both, o.ready_after, o.err_after, err_count, exp_errcnt());
            end
        end
        n_checks++;
        if (ram_refire != 0 || io_refire != 0) begin
            n_fail++; $display("FAIL rnd_refire: ram %0d io %0d expected 0 0", ram_refire, io_refire);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic was_valid;
        ram_lat = 30;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = RB + 32'h14; cpu_wdata = '0; cpu_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        was_valid = ram_valid;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (was_valid !== 1'b1 || ram_valid !== 1'b0 || cpu_ready !== 1'b0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid: before %b valid %b ready %b cnt %0d expected 1 0 0 0", was_valid, ram_valid, cpu_ready, err_count);
        end
        cpu_valid = 1'b0;
        ref_err = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ram_lat = 1;
        drive_access(RB + 32'h14, 32'h0, 4'h0, o);
        n_checks++;
        if (o.rdata !== ref_ram[5] || o.err !== 1'b0 || o.lat != 3) begin
            n_fail++; $display("FAIL reset_recover: data %h err %b lat %0d expected %h 0 3", o.rdata, o.err, o.lat, ref_ram[5]);
        end
        for (int i = 0; i < 300; i++) begin
            drive_access(32'h2000_0000 + 32'(i * 4), 32'h0, 4'h0, o);
            ref_err++;
        end
        n_checks++;
        if (err_count !== 8'(exp_errcnt()) || o.err !== 1'b1) begin
            n_fail++; $display("FAIL err_saturate: cnt %0d err %b expected %0d 1", err_count, o.err, exp_errcnt());
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 4096; i++) begin v = $urandom; slv_ram[i] = v; ref_ram[i] = v; end
        for (int i = 0; i < 1024; i++) begin v = $urandom; slv_io[i] = v; ref_io[i] = v; end
        resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_ram_read();
        test_io_write();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_random(200);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_bus_decoder
`default_nettype wire

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
Sits between the CPU native memory port (valid/ready, addr, wdata, wstrb) and the slaves: on-chip RAM and one IO window. Decodes each CPU request, forwards it to exactly one slave with a base-relative address, and returns that slave's data to the CPU through a registered one-cycle ready. Unmapped accesses and slaves that exceed a timeout get an error response, so the CPU never hangs.

Parameters:
RAM_BASE, 32'h0000_0000, byte base of RAM window
RAM_BYTES, 16384, RAM window size in bytes; power of two; matches 4096-word RAM
IO_BASE, 32'h1000_0000, byte base of IO window
IO_BYTES, 4096, IO window size in bytes; power of two
TIMEOUT, 255, max cycles to wait for slave ready; range 1..255
ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
cpu_valid  in  1  CPU request valid; held until cpu_ready
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_wstrb  in  4  byte strobes; 0 = read
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data; valid while cpu_ready=1
ram_valid  out  1  RAM request
ram_addr  out  32  cpu_addr - RAM_BASE
ram_wdata  out  32  forwarded cpu_wdata
ram_wstrb  out  4  forwarded cpu_wstrb
ram_ready  in  1  RAM completion
ram_rdata  in  32  RAM read data
io_valid  out  1  IO request
io_addr  out  32  cpu_addr - IO_BASE
io_wdata  out  32  forwarded cpu_wdata
io_wstrb  out  4  forwarded cpu_wstrb
io_ready  in  1  IO completion
io_rdata  in  32  IO read data
bus_error  out  1  one-cycle pulse coincident with an error cpu_ready
err_count  out  8  saturating count of errors

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; cpu_ready=0, cpu_rdata=0, ram_valid=0, io_valid=0, bus_error=0, err_count=0, timer=0. Any in-flight access is dropped; slave valids fall immediately.
- Decode: hit_ram when RAM_BASE <= addr < RAM_BASE+RAM_BYTES; hit_io likewise; windows do not overlap. Address/wdata/wstrb to slaves are registered at request acceptance and held stable for the access.
- States: IDLE, RAM, IO, RESP.
- IDLE: if cpu_valid and hit_ram -> RAM, ram_valid<=1 next edge. If hit_io -> IO, io_valid<=1. If unmapped -> RESP with cpu_rdata<=ERR_DATA, bus_error<=1, error increments. No slave strobe for unmapped.
- RAM/IO: timer counts up each cycle. On slave ready=1: latch slave rdata into cpu_rdata (rdata is don't-care for writes but still latched), drop slave valid at the same edge, -> RESP. If timer reaches TIMEOUT without ready: drop slave valid, cpu_rdata<=ERR_DATA, bus_error<=1, -> RESP.
- RESP: cpu_ready=1 and bus_error as set for exactly this one cycle; timer cleared; -> IDLE unconditionally. The next request is accepted in IDLE, so minimum spacing between slave valids is 2 idle cycles. This guarantees the RAM, which re-fires on valid&&!ready, never sees valid in the cycle after its ready.
- Latency (request at edge 0): RAM responding 1 cycle after valid gives cpu_ready 3 cycles after cpu_valid rises. Unmapped gives cpu_ready 1 cycle after cpu_valid.
- Only one slave valid is ever high; both are low outside RAM/IO states.
- A slave ready arriving while that slave is not addressed is ignored.
- Ready and timeout on the same edge: ready wins, no error.
- err_count: +1 per error, saturates at 255 and does not wrap.
- cpu_valid dropping mid-access (protocol violation): access still completes; the response is still issued.

Decomposition:
- Shared package: state encoding (IDLE/RAM/IO/RESP), ERR_DATA default, memory-map base/size constants reused by the firmware linker script and the top level.
- One natural sub-module, bus_timeout_timer: clear/enable 8-bit counter with an expired flag at TIMEOUT. Everything else stays in mem_bus_decoder.

Test Plan:
- Read RAM: RAM preloaded word[5]=32'h1234_5678; cpu read addr 0x14 -> ram_addr=0x14, ram_valid high 1 cycle, cpu_ready pulse with cpu_rdata=32'h1234_5678, bus_error=0.
- Byte write IO: cpu write addr 0x1000_0008, wdata 0xAB, wstrb 4'b0001 -> io_valid, io_addr=0x8, io_wstrb=4'b0001, ram_valid stays 0, cpu_ready one cycle after io_ready.
- Unmapped: read addr 0x2000_0000 -> no slave valid, cpu_ready next cycle, cpu_rdata=32'hDEAD_BEEF, bus_error=1, err_count=1.
- Timeout: io_ready tied 0, TIMEOUT=4, IO read -> io_valid high exactly 4 cycles then low, cpu_ready with DEADBEEF, err_count increments.
- Back-to-back: cpu_valid held high across two RAM reads -> ram_valid low at least one cycle between them, each read returns correct data, RAM never returns a duplicate ready.
- Reset mid-access: assert resetn=0 while in RAM state -> ram_valid and cpu_ready drop immediately; after release, a read of 0x14 completes normally. Also check 300 unmapped accesses leave err_count=255.
